imm_pack: RTL

//   Inverse of the immediate extender: takes a 32-bit constant and finds the
//   16-bit immediate plus EOp code that the extender expands back to it exactly.

---
 rtl/imm_pack.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imm_pack.sv
// Finds the 16-bit immediate and extender mode that reproduce a 32-bit constant,
// testing one mode per cycle and falling back to a lui/ori split when none fits.
module imm_pack #(
    parameter bit SKIP_SHIFT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] imm,
    output logic [1:0]  EOp,
    output logic        split,
    output logic [15:0] imm_hi
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    localparam logic [1:0] LAST_MODE = SKIP_SHIFT ? 2'd2 : 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] val_q, val_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] imm_q, imm_d;
    logic [1:0]  eop_q, eop_d;
    logic        split_q, split_d;
    logic [15:0] imm_hi_q, imm_hi_d;

    logic [3:0]  hit;
    logic [15:0] cand_imm;

    // Each bit says whether the extender in that mode can rebuild val_q exactly.
    always_comb begin
        hit[0] = (&val_q[31:15]) | ~(|val_q[31:15]);
        hit[1] = ~(|val_q[31:16]);
        hit[2] = ~(|val_q[15:0]);
        hit[3] = ~(|val_q[1:0]) & ((&val_q[31:17]) | ~(|val_q[31:17]));
    end

    always_comb begin
        case (mode_q)
            2'd2:    cand_imm = val_q[31:16];
            2'd3:    cand_imm = val_q[17:2];
            default: cand_imm = val_q[15:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        val_d       = val_q;
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        eop_d       = eop_q;
        split_d     = split_q;
        imm_hi_d    = imm_hi_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d   = value;
                    mode_d  = 2'd0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit[mode_q]) begin
                    imm_d       = cand_imm;
                    eop_d       = mode_q;
                    split_d     = 1'b0;
                    imm_hi_d    = 16'h0000;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mode_q == LAST_MODE) begin
                    imm_d       = val_q[15:0];
                    eop_d       = 2'b01;
                    split_d     = 1'b1;
                    imm_hi_d    = val_q[31:16];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    mode_d = mode_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            val_q       <= 32'h0;
            out_valid_q <= 1'b0;
            imm_q       <= 16'h0;
            eop_q       <= 2'b00;
            split_q     <= 1'b0;
            imm_hi_q    <= 16'h0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            val_q       <= val_d;
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            eop_q       <= eop_d;
            split_q     <= split_d;
            imm_hi_q    <= imm_hi_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign imm       = imm_q;
    assign EOp       = eop_q;
    assign split     = split_q;
    assign imm_hi    = imm_hi_q;

endmodule
